mc_id_cfg_ctrl: RTL
===================

Name: mc_id_cfg_ctrl

Overview:
Configuration sequencer for the multicast-controller (MC) array.
- Accepts a stream of ID words from the top-level config path over a valid/ready handshake and stores one word per MC in shadow registers.
- Once all NUM_MC words are held, commits them to every MC in a single cycle with a one-cycle id_valid strobe.
- Sits between the top controller's config scan path and the MC instances of one GLB-to-PE bus.

Parameters:
ID_BITWIDTH, 4, width of one MC ID/tag.
NUM_MC, 12, number of MCs configured by this block; legal range 1..255.
IDX_BITWIDTH, 8, width of the internal word index; must satisfy 2^IDX_BITWIDTH > NUM_MC.

Ports:
i_clk  input  1  clock; all state updates on its rising edge.
i_rst_n  input  1  reset, asynchronous, active-low.
i_start  input  1  begins a configuration pass; sampled only in IDLE.
i_abort  input  1  abandons a pass in progress; no commit is issued.
i_cfg_data  input  ID_BITWIDTH  next ID word; word k is destined for MC k.
i_cfg_valid  input  1  i_cfg_data is valid.
o_cfg_ready  output  1  block accepts a word this cycle.
o_id  output  NUM_MC*ID_BITWIDTH  shadow IDs, flattened; MC k uses bits [k*ID_BITWIDTH +: ID_BITWIDTH].
o_id_valid  output  NUM_MC  per-MC load strobe.
i_cur_id  input  NUM_MC*ID_BITWIDTH  flattened o_cur_id readback from the MCs; used only with MC_ID_VERIFY_EN.
o_busy  output  1  high in every state except IDLE.
o_done  output  1  one-cycle pulse when a pass completes.
o_err  output  1  sticky verify-mismatch flag; constant 0 without MC_ID_VERIFY_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, index=0, all shadow registers=0, o_id=0, o_id_valid=0, o_cfg_ready=0, o_busy=0, o_done=0, o_err=0.
- States: IDLE, LOAD, COMMIT, VERIFY (present only with the macro), DONE.
- IDLE:
  - i_start=1 -> LOAD; index cleared to 0; o_err cleared.
  - i_start is ignored in all other states.
- LOAD:
  - o_cfg_ready=1.
  - Handshake i_cfg_valid && o_cfg_ready writes shadow[index] and increments index.
  - The handshake that writes index NUM_MC-1 moves to COMMIT on the next edge; o_cfg_ready is 0 from then on. No word is ever accepted beyond NUM_MC.
  - Holding i_cfg_valid=0 stalls indefinitely.
- COMMIT:
  - Exactly one cycle with o_id_valid = all ones and o_id = shadow contents.
  - Next state is VERIFY if the macro is defined, otherwise DONE.
- DONE: one cycle; o_done=1; then IDLE.
- o_id always reflects the shadow registers. MCs load them only on the o_id_valid strobe, so partial or aborted passes never reach the MCs.
- i_abort:
  - In LOAD or COMMIT: next state is IDLE and o_done is not pulsed.
  - Shadow words already written keep their new values.
  - A word handshake in the same cycle as i_abort is still written, but no commit follows.
  - In IDLE or DONE: i_abort has no effect.
- Simultaneous i_start and i_abort in IDLE: i_start wins.
- Reset mid-pass: all state returns to reset values immediately. o_id_valid must never glitch high on reset.
- Latency: NUM_MC accepted words plus 2 cycles (COMMIT, DONE) from the first handshake cycle to o_done; plus 1 cycle with the macro.
- All outputs are registered or decoded from the state register; there is no combinational path from i_cfg_valid to o_cfg_ready.

Optional Feature:
MC_ID_VERIFY_EN:
- Defined: after COMMIT the FSM enters VERIFY for one cycle. It compares i_cur_id against the shadow registers and sets o_err=1 on any mismatch; o_err stays 1 until the next i_start or reset. The FSM then enters DONE.
- Undefined: the VERIFY state and comparator are absent, i_cur_id is unused, and o_err is tied to 0.

Test Plan:
1. Reset, then i_start with NUM_MC=12 and words 0..11 streamed back-to-back -> o_id_valid=12'hFFF for exactly 1 cycle; o_id[k]=k; o_done pulses 2 cycles after the last handshake (3 with the macro).
2. Same stream with i_cfg_valid de-asserted for 5 cycles after word 6 -> o_cfg_ready stays 1, no extra writes; final o_id identical to scenario 1.
3. Send 8 words F..8, i_abort in the same cycle as word 4 -> word 4 written, no o_id_valid, no o_done; o_busy=0 next cycle; shadow[0..4]=F,E,D,C,B.
4. Keep i_cfg_valid high after word 11 -> o_cfg_ready=0 from COMMIT onward; exactly 12 words consumed.
5. Assert i_rst_n low during LOAD at word 5 -> all outputs 0 immediately; a new i_start restarts the pass at index 0.
6. With MC_ID_VERIFY_EN: drive i_cur_id so that MC 3 differs from shadow -> o_err=1 after VERIFY, remaining 1 through IDLE; next i_start clears it.

Source files
------------

// File: rtl/mc_id_cfg_ctrl.sv
// Collects NUM_MC ID words over valid/ready, then strobes them to all MCs at once; o_done NUM_MC+2 cycles after the first word (+1 with MC_ID_VERIFY_EN).
// o_cfg_ready is decoded from state only; i_cfg_valid low stalls LOAD indefinitely. MC_ID_VERIFY_EN adds a readback compare cycle.
module mc_id_cfg_ctrl #(
   parameter int ID_BITWIDTH  = 4,
   parameter int NUM_MC       = 12,
   parameter int IDX_BITWIDTH = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_start,
   input  logic                          i_abort,
   input  logic [ID_BITWIDTH-1:0]        i_cfg_data,
   input  logic                          i_cfg_valid,
   output logic                          o_cfg_ready,
   output logic [NUM_MC*ID_BITWIDTH-1:0] o_id,
   output logic [NUM_MC-1:0]             o_id_valid,
   input  logic [NUM_MC*ID_BITWIDTH-1:0] i_cur_id,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_err
);

   localparam int W = NUM_MC * ID_BITWIDTH;
   localparam logic [IDX_BITWIDTH-1:0] LAST_IDX = IDX_BITWIDTH'(NUM_MC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMMIT,
      S_DONE
`ifdef MC_ID_VERIFY_EN
      , S_VERIFY
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_BITWIDTH-1:0] idx_q, idx_d;
   logic [W-1:0]            shadow_q, shadow_d;
   logic                    wr;

`ifdef MC_ID_VERIFY_EN
   logic err_q, err_d;
`else
   logic unused_cur_id;
   assign unused_cur_id = ^i_cur_id;
`endif

   assign wr = (state_q == S_LOAD) && i_cfg_valid;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
`ifdef MC_ID_VERIFY_EN
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_LOAD;
               idx_d   = '0;
`ifdef MC_ID_VERIFY_EN
               err_d   = 1'b0;
`endif
            end
         end
         S_LOAD: begin
            if (wr) idx_d = idx_q + IDX_BITWIDTH'(1);
            // abort still lets a same-cycle word land in the shadow, but never commits
            if (i_abort)                       state_d = S_IDLE;
            else if (wr && idx_q == LAST_IDX)  state_d = S_COMMIT;
         end
         S_COMMIT: begin
            if (i_abort) state_d = S_IDLE;
`ifdef MC_ID_VERIFY_EN
            else         state_d = S_VERIFY;
`else
            else         state_d = S_DONE;
`endif
         end
`ifdef MC_ID_VERIFY_EN
         S_VERIFY: begin
            if (i_cur_id != shadow_q) err_d = 1'b1;
            state_d = S_DONE;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      for (int k = 0; k < NUM_MC; k++) begin
         if (wr && idx_q == IDX_BITWIDTH'(k)) shadow_d[k*ID_BITWIDTH +: ID_BITWIDTH] = i_cfg_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
      end
   end

`ifdef MC_ID_VERIFY_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) err_q <= 1'b0;
      else          err_q <= err_d;
   end
   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

   // strobe is a pure state decode, so async reset drops it without a glitch
   assign o_cfg_ready = (state_q == S_LOAD);
   assign o_id_valid  = {NUM_MC{state_q == S_COMMIT}};
   assign o_id        = shadow_q;
   assign o_busy      = (state_q != S_IDLE);
   assign o_done      = (state_q == S_DONE);

endmodule
